hazard_ctrl: RTL and testbench

//   Pipeline hazard/stall sequencer for the 4-bit-register-index pipeline; pairs with the forwarding unit.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_ctrl_mem_wait_timer.sv | 43 ++++
 rtl/hazard_ctrl.sv | 170 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants for the hazard/stall sequencer.
//   Purpose : FSM state encoding and default register-index width.
//   Latency : n/a (constants only). Backpressure: n/a.
//   Ports   : none.
package hazard_pkg;

   localparam int IDXW_DEF = 4;

   // Sequencer states (2-bit encoding kept stable for legacy tooling).
   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_DRAIN    = 2'd2;
   localparam logic [1:0] ST_TIMEOUT  = 2'd3;

endpackage

// File: rtl/hazard_ctrl_mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting on a slow memory access.
//   Latency : count updates on the clock edge after load/clr/inc; at_max_o is combinational from the count.
//   Backpressure: none; the owner decides when to load, clear or increment.
//   Ports   : clk/rst (async active-high), load_i (count<=1), clr_i (count<=0),
//             inc_i (count<=count+1), at_max_o (count==MAX_WAIT).
module mem_wait_timer #(
   parameter int CNTW     = 4,
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic at_max_o
);

   logic [CNTW-1:0] cnt_q;
   logic [CNTW-1:0] cnt_d;

   // Load wins over clear, clear over increment; the owner never asserts two at once.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CNTW'(1);
      end else if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + CNTW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_max_o = (cnt_q == CNTW'(MAX_WAIT));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard/stall sequencer (load-use stall, branch flush, slow-memory freeze).
//   Latency : control outputs are Mealy (same cycle as inputs); mem_err is registered.
//   Backpressure: freeze holds every pipeline register while memory is not ready; stall_pc/stall_ifid hold front end.
//   Ports   : inputs clk, rst (async active-high), id_valid, id_rs1, id_rs2, id_use1, id_use2, ex_load,
//             ex_wr_idx, ex_regwrite, branch_taken, mem_req, mem_ready; outputs stall_pc, stall_ifid,
//             bubble_idex, flush_ifid, freeze, mem_err.
//   Optional: define HAZARD_STATS_EN to add saturating counters stall_cycles[15:0] and flush_count[15:0].
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int IDXW     = IDXW_DEF,
   parameter int MAX_WAIT = 15,
   parameter int CNTW     = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [IDXW-1:0] id_rs1,
   input  logic [IDXW-1:0] id_rs2,
   input  logic            id_use1,
   input  logic            id_use2,
   input  logic            ex_load,
   input  logic [IDXW-1:0] ex_wr_idx,
   input  logic            ex_regwrite,
   input  logic            branch_taken,
   input  logic            mem_req,
   input  logic            mem_ready,
   output logic            stall_pc,
   output logic            stall_ifid,
   output logic            bubble_idex,
   output logic            flush_ifid,
   output logic            freeze,
   output logic            mem_err
`ifdef HAZARD_STATS_EN
   ,
   output logic [15:0]     stall_cycles,
   output logic [15:0]     flush_count
`endif
);

   logic [1:0] state_q, state_d;
   logic       pend_flush_q, pend_flush_d;
   logic       mem_err_q, mem_err_d;

   logic       tmr_load, tmr_clr, tmr_inc, tmr_at_max;
   logic       load_use;
   logic       stall_c, bubble_c, flush_c, freeze_c;

   mem_wait_timer #(
      .CNTW     (CNTW),
      .MAX_WAIT (MAX_WAIT)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load_i   (tmr_load),
      .clr_i    (tmr_clr),
      .inc_i    (tmr_inc),
      .at_max_o (tmr_at_max)
   );

   // Register 0 gets no special treatment: a load to index 0 still stalls its consumer.
   assign load_use = ex_load & ex_regwrite & id_valid &
                     ((id_use1 & (id_rs1 == ex_wr_idx)) | (id_use2 & (id_rs2 == ex_wr_idx)));

   always_comb begin
      state_d      = state_q;
      pend_flush_d = pend_flush_q;
      mem_err_d    = mem_err_q;
      tmr_load     = 1'b0;
      tmr_clr      = 1'b0;
      tmr_inc      = 1'b0;
      stall_c      = 1'b0;
      bubble_c     = 1'b0;
      flush_c      = 1'b0;
      freeze_c     = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (mem_req && !mem_ready) begin
               // Freeze dominates: a branch arriving now is remembered and replayed as DRAIN.
               freeze_c     = 1'b1;
               tmr_load     = 1'b1;
               pend_flush_d = branch_taken;
               state_d      = ST_MEM_WAIT;
            end else if (branch_taken) begin
               flush_c  = 1'b1;
               bubble_c = 1'b1;
            end else if (load_use) begin
               stall_c  = 1'b1;
               bubble_c = 1'b1;
            end
         end

         ST_MEM_WAIT: begin
            freeze_c = !mem_ready;
            if (branch_taken) begin
               pend_flush_d = 1'b1;
            end
            if (mem_ready) begin
               tmr_clr = 1'b1;
               state_d = (pend_flush_q || branch_taken) ? ST_DRAIN : ST_RUN;
            end else if (tmr_at_max) begin
               state_d   = ST_TIMEOUT;
               mem_err_d = 1'b1;
            end else begin
               tmr_inc = 1'b1;
            end
         end

         ST_DRAIN: begin
            flush_c      = 1'b1;
            bubble_c     = 1'b1;
            pend_flush_d = 1'b0;
            state_d      = ST_RUN;
         end

         ST_TIMEOUT: begin
            // Terminal until reset; a late mem_ready cannot revive the pipe.
            freeze_c = 1'b1;
         end

         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_RUN;
         pend_flush_q <= 1'b0;
         mem_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_flush_q <= pend_flush_d;
         mem_err_q    <= mem_err_d;
      end
   end

   // Mealy outputs are forced low while reset is asserted.
   assign stall_pc    = stall_c  & ~rst;
   assign stall_ifid  = stall_c  & ~rst;
   assign bubble_idex = bubble_c & ~rst;
   assign flush_ifid  = flush_c  & ~rst;
   assign freeze      = freeze_c & ~rst;
   assign mem_err     = mem_err_q;

`ifdef HAZARD_STATS_EN
   logic [15:0] stall_cycles_q;
   logic [15:0] flush_count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         if ((freeze || stall_pc) && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_q <= stall_cycles_q + 16'd1;
         end
         if (flush_ifid && (flush_count_q != 16'hFFFF)) begin
            flush_count_q <= flush_count_q + 16'd1;
         end
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized traffic for hazard_ctrl,
//   checked cycle by cycle against a behavioural model of the stall/flush/freeze rules.
//   Optional: HAZARD_STATS_EN enables checking of the statistics counters.
module tb_hazard_ctrl;

   localparam int IDXW     = 4;
   localparam int MAX_WAIT = 15;
   localparam int CNTW     = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            id_valid, id_use1, id_use2, ex_load, ex_regwrite;
   logic [IDXW-1:0] id_rs1, id_rs2, ex_wr_idx;
   logic            branch_taken, mem_req, mem_ready;
   logic            stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze, mem_err;
`ifdef HAZARD_STATS_EN
   logic [15:0]     stall_cycles, flush_count;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.IDXW(IDXW), .MAX_WAIT(MAX_WAIT), .CNTW(CNTW)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_use1      (id_use1),
      .id_use2      (id_use2),
      .ex_load      (ex_load),
      .ex_wr_idx    (ex_wr_idx),
      .ex_regwrite  (ex_regwrite),
      .branch_taken (branch_taken),
      .mem_req      (mem_req),
      .mem_ready    (mem_ready),
      .stall_pc     (stall_pc),
      .stall_ifid   (stall_ifid),
      .bubble_idex  (bubble_idex),
      .flush_ifid   (flush_ifid),
      .freeze       (freeze),
      .mem_err      (mem_err)
`ifdef HAZARD_STATS_EN
      ,
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
`endif
   );

   // ---------------- behavioural model ----------------
   bit access_open;     // a slow memory access is outstanding
   int frozen_so_far;   // frozen cycles already spent on that access
   bit redirect_seen;   // a branch arrived while the access was outstanding
   bit drain_due;       // this cycle replays the remembered redirect
   bit dead;            // memory never answered; pipe stays frozen
   bit m_err;
   int m_stalls;
   int m_flushes;
   bit e_stall, e_bubble, e_flush, e_freeze;

   function automatic bit hazard_now();
      return id_valid && ex_load && ex_regwrite &&
             ((id_use1 && id_rs1 == ex_wr_idx) || (id_use2 && id_rs2 == ex_wr_idx));
   endfunction

   task automatic model_reset();
      access_open = 0; frozen_so_far = 0; redirect_seen = 0;
      drain_due = 0; dead = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
   endtask

   task automatic model_outputs();
      e_stall = 0; e_bubble = 0; e_flush = 0; e_freeze = 0;
      if (rst) return;
      if (dead) e_freeze = 1;
      else if (drain_due) begin e_flush = 1; e_bubble = 1; end
      else if (access_open) e_freeze = !mem_ready;
      else if (mem_req && !mem_ready) e_freeze = 1;
      else if (branch_taken) begin e_flush = 1; e_bubble = 1; end
      else if (hazard_now()) begin e_stall = 1; e_bubble = 1; end
   endtask

   task automatic model_advance();
      if (e_freeze || e_stall) m_stalls = (m_stalls < 65535) ? m_stalls + 1 : 65535;
      if (e_flush) m_flushes = (m_flushes < 65535) ? m_flushes + 1 : 65535;
      if (dead) return;
      if (drain_due) drain_due = 0;
      else if (access_open) begin
         if (mem_ready) begin
            access_open   = 0;
            drain_due     = redirect_seen || branch_taken;
            redirect_seen = 0;
         end else begin
            redirect_seen = redirect_seen || branch_taken;
            frozen_so_far++;
            if (frozen_so_far == MAX_WAIT + 1) begin dead = 1; m_err = 1; end
         end
      end else if (mem_req && !mem_ready) begin
         access_open = 1; frozen_so_far = 1; redirect_seen = branch_taken;
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic check(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Inputs are already applied; check mid-cycle, then take one clock.
   task automatic step(input string tag);
      #2;
      if (rst) model_reset();
      model_outputs();
      check({tag, ".stall_pc"},    stall_pc,    e_stall);
      check({tag, ".stall_ifid"},  stall_ifid,  e_stall);
      check({tag, ".bubble_idex"}, bubble_idex, e_bubble);
      check({tag, ".flush_ifid"},  flush_ifid,  e_flush);
      check({tag, ".freeze"},      freeze,      e_freeze);
      check({tag, ".mem_err"},     mem_err,     m_err);
`ifdef HAZARD_STATS_EN
      check16({tag, ".stall_cycles"}, stall_cycles, 16'(m_stalls));
      check16({tag, ".flush_count"},  flush_count,  16'(m_flushes));
`endif
      @(posedge clk);
      if (!rst) model_advance();
      #1;
   endtask

   task automatic idle();
      id_valid = 0; id_use1 = 0; id_use2 = 0; ex_load = 0; ex_regwrite = 0;
      id_rs1 = '0; id_rs2 = '0; ex_wr_idx = '0;
      branch_taken = 0; mem_req = 0; mem_ready = 0;
   endtask

   task automatic set_t1_hazard();
      ex_load = 1; ex_regwrite = 1; ex_wr_idx = 4'd5; id_rs2 = 4'd5; id_use2 = 1;
      id_valid = 1; id_rs1 = 4'd2; id_use1 = 1;
   endtask

   task automatic do_reset();
      rst = 1;
      step("reset");
      rst = 0;
   endtask

   initial begin
      idle();
      rst = 1;
      model_reset();
      #1;
      step("reset0");
      check("reset.freeze_const", freeze, 1'b0);
      step("reset1");
      rst = 0;

      // T1: load-use hazard on rs2, then the same without the rs2 use
      set_t1_hazard();
      step("t1_hit");
      id_use2 = 0;
      #2 check("t1_nouse_const", stall_pc, 1'b0);
      step("t1_nouse");
      // index 0 still counts as a dependency
      ex_wr_idx = 4'd0; id_rs1 = 4'd0; id_use1 = 1;
      step("t1_idx0");
      id_valid = 0;
      step("t1_invalid");

      // T2: branch beats the load-use hazard
      idle(); set_t1_hazard(); branch_taken = 1;
      #2 check("t2_stall_const", stall_pc, 1'b0);
      step("t2_branch");
      idle();
      step("t2_after");

      // T3: three frozen cycles then ready; back in RUN afterwards
      mem_req = 1; mem_ready = 0;
      step("t3_w0"); step("t3_w1"); step("t3_w2");
      mem_ready = 1;
      #2 check("t3_ready_freeze_const", freeze, 1'b0);
      step("t3_ready");
      idle(); set_t1_hazard();
      step("t3_run_hazard");
      idle();
      // zero-wait access: no freeze, branch rule still applies
      mem_req = 1; mem_ready = 1; branch_taken = 1;
      step("t3_zero_wait");
      idle();

      // T4: branch in the 2nd MEM_WAIT cycle, then ready -> DRAIN
      mem_req = 1;
      step("t4_run");
      mem_req = 0;
      step("t4_mw1");
      branch_taken = 1;
      step("t4_mw2_branch");
      branch_taken = 0; mem_ready = 1;
      step("t4_ready");
      mem_ready = 0;
      #2 check("t4_drain_flush_const", flush_ifid, 1'b1);
      step("t4_drain");
      step("t4_run_after");

      // T5: memory never answers -> TIMEOUT after 16 frozen cycles
      mem_req = 1;
      for (int i = 0; i < MAX_WAIT + 1; i++) step("t5_wait");
      mem_req = 0;
      #2 check("t5_err_const", mem_err, 1'b1);
      step("t5_timeout");
      mem_ready = 1;
      step("t5_late_ready");
      mem_ready = 0; set_t1_hazard();
      step("t5_still_dead");
      idle();
      rst = 1;
      #2 check("t5_rst_err_const", mem_err, 1'b0);
      step("t5_rst");
      rst = 0;
      step("t5_run");

      // mid-operation reset discards a pending flush
      mem_req = 1; branch_taken = 1;
      step("mid_run");
      idle();
      step("mid_wait");
      rst = 1;
      step("mid_rst");
      rst = 0; mem_ready = 1;
      step("mid_after");
      mem_ready = 0;
      step("mid_no_drain");

`ifdef HAZARD_STATS_EN
      // T6: T3 followed by T2
      do_reset();
      mem_req = 1;
      step("t6_w0"); step("t6_w1"); step("t6_w2");
      mem_ready = 1;
      step("t6_ready");
      idle(); set_t1_hazard(); branch_taken = 1;
      step("t6_branch");
      idle();
      #2;
      check16("t6_stall_const", stall_cycles, 16'd3);
      check16("t6_flush_const", flush_count, 16'd1);
`endif

      // randomized traffic
      do_reset();
      for (int n = 0; n < 800; n++) begin
         rst          = ($urandom_range(0, 99) == 0);
         id_valid     = $urandom_range(0, 3) != 0;
         id_use1      = $urandom_range(0, 1);
         id_use2      = $urandom_range(0, 1);
         ex_load      = $urandom_range(0, 1);
         ex_regwrite  = $urandom_range(0, 3) != 0;
         id_rs1       = IDXW'($urandom_range(0, 3));
         id_rs2       = IDXW'($urandom_range(0, 3));
         ex_wr_idx    = IDXW'($urandom_range(0, 3));
         branch_taken = ($urandom_range(0, 7) == 0);
         mem_req      = ($urandom_range(0, 5) == 0);
         mem_ready    = ($urandom_range(0, 2) == 0);
         step("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
